// File: rtl/video_filter_pkg.sv
// Shared types and constants for the 2-D convolution video filter.
package video_filter_pkg;

  localparam int FILTER_DIM  = 5;
  localparam int COE_WIDTH   = 16;
  localparam int KERNEL_SIZE = FILTER_DIM * FILTER_DIM;

  typedef logic signed [COE_WIDTH-1:0] coe_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    SWAP
  } state_t;

endpackage

// File: rtl/coe_bank_regfile.sv
// Shadow and active coefficient banks: per-index write, copy-all, optional read.
// Optional readback port when COE_READBACK_EN is defined.
module coe_bank_regfile #(
  parameter int                   DEPTH     = 25,
  parameter int                   COE_WIDTH = 16,
  parameter int                   ADDR_W    = 8,
  parameter logic [COE_WIDTH-1:0] RESET_COE = '1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [COE_WIDTH-1:0]       wr_data,
  input  logic                       copy_all,
`ifdef COE_READBACK_EN
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_sel,
  output logic [COE_WIDTH-1:0]       rd_data,
`endif
  output logic [DEPTH*COE_WIDTH-1:0] active_flat
);

  logic [COE_WIDTH-1:0] shadow [DEPTH];
  logic [COE_WIDTH-1:0] active [DEPTH];

  // Writes and copy are never requested together; the FSM only copies when writes are locked out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        shadow[k] <= RESET_COE;
        active[k] <= RESET_COE;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en && wr_addr == ADDR_W'(k)) shadow[k] <= wr_data;
        if (copy_all) active[k] <= shadow[k];
      end
    end
  end

  always_comb begin
    active_flat = '0;
    for (int k = 0; k < DEPTH; k++) active_flat[k*COE_WIDTH +: COE_WIDTH] = active[k];
  end

`ifdef COE_READBACK_EN
  logic [COE_WIDTH-1:0] rd_mux;

  // No index matches an out-of-range address, so it reads back as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_mux = rd_sel ? shadow[k] : active[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= rd_mux;
  end
`endif

endmodule

// File: rtl/coe_bank_ctrl.sv
// Coefficient-set controller: double-buffered kernel swapped only on an accepted SOF.
// Optional shadow/active readback port when COE_READBACK_EN is defined.
//
// state | meaning
// IDLE  | no shadow writes since last swap or reset
// LOAD  | at least one shadow write accepted
// ARMED | commit waiting for start-of-frame
// SWAP  | one-cycle swap indication
module coe_bank_ctrl
  import video_filter_pkg::*;
#(
  parameter int                   FILTER_DIM = video_filter_pkg::FILTER_DIM,
  parameter int                   COE_WIDTH  = video_filter_pkg::COE_WIDTH,
  parameter int                   ADDR_W     = 8,
  parameter logic [COE_WIDTH-1:0] RESET_COE  = COE_WIDTH'(16'h7FFF)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_wr_en,
  input  logic [ADDR_W-1:0]                      cfg_wr_addr,
  input  logic [COE_WIDTH-1:0]                   cfg_wr_data,
  input  logic                                   cfg_commit,
  output logic                                   cfg_err,
  output logic                                   cfg_pending,
`ifdef COE_READBACK_EN
  input  logic [ADDR_W-1:0]                      cfg_rd_addr,
  input  logic                                   cfg_rd_sel,
  output logic [COE_WIDTH-1:0]                   cfg_rd_data,
`endif
  input  logic                                   vid_tvalid,
  input  logic                                   vid_tready,
  input  logic                                   vid_tuser,
  output logic [FILTER_DIM*FILTER_DIM*COE_WIDTH-1:0] coe_flat,
  output logic                                   coe_update,
  output logic [15:0]                            frame_cnt
);

  localparam int KSIZE = FILTER_DIM * FILTER_DIM;

  state_t state, state_nxt;
  logic   sof, addr_ok, wr_ok, wr_rej, copy_all;

  assign sof      = vid_tvalid & vid_tready & vid_tuser;
  // Extra bit keeps the bound exact when 2**ADDR_W equals the kernel size.
  assign addr_ok  = {1'b0, cfg_wr_addr} < (ADDR_W+1)'(KSIZE);
  assign wr_rej   = cfg_wr_en & ~wr_ok;
  assign copy_all = (state == ARMED) & sof;

  always_comb begin
    state_nxt = state;
    wr_ok     = 1'b0;
    case (state)
      IDLE: begin
        wr_ok = cfg_wr_en & addr_ok;
        if (cfg_commit)  state_nxt = ARMED;
        else if (wr_ok)  state_nxt = LOAD;
      end
      LOAD: begin
        wr_ok = cfg_wr_en & addr_ok;
        if (cfg_commit) state_nxt = ARMED;
      end
      ARMED:   if (sof) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cfg_err    <= 1'b0;
      coe_update <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      cfg_err    <= wr_rej;
      coe_update <= copy_all;
      if (sof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign cfg_pending = (state == ARMED);

  coe_bank_regfile #(
    .DEPTH     (KSIZE),
    .COE_WIDTH (COE_WIDTH),
    .ADDR_W    (ADDR_W),
    .RESET_COE (RESET_COE)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_ok),
    .wr_addr     (cfg_wr_addr),
    .wr_data     (cfg_wr_data),
    .copy_all    (copy_all),
`ifdef COE_READBACK_EN
    .rd_addr     (cfg_rd_addr),
    .rd_sel      (cfg_rd_sel),
    .rd_data     (cfg_rd_data),
`endif
    .active_flat (coe_flat)
  );

endmodule
